qbus_reg_slave: RTL and testbench

Bus-side responder for QBUS programmed-I/O cycles that target the card's device registers. It latches the I/O-page address at SYNC, presents it to the register read mux and devices, and checks the returned match. It then sequences DATI, DATO(B) and DATIO(B) data phases: it drives read data and RPLY, and issues single-cycle read/write strobes to the devices. It sits between the synchronized bus front end and the register control mux.

---
 rtl/qbus_reg_slave.sv | 130 +++++++++++++
 tb/tb_qbus_reg_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_reg_slave.sv
// QBUS programmed-I/O responder for the card's device registers.
// It decodes the I/O-page address at SYNC, then runs DATI/DATO(B)/DATIO(B) data phases.
module qbus_reg_slave #(
  parameter int RPLY_DELAY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_sync,
  input  logic        bus_din,
  input  logic        bus_dout,
  input  logic        bus_wtbt,
  input  logic        bus_bs7,
  input  logic [21:0] bus_ad,
  output logic        bus_rply,
  output logic        bus_da_oe,
  output logic [15:0] bus_da_out,
  output logic [12:0] reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [15:0] reg_wdata,
  output logic [1:0]  reg_bmask,
  input  logic        reg_addr_match,
  input  logic [15:0] reg_rdata
);

  localparam int CW = (RPLY_DELAY > 1) ? $clog2(RPLY_DELAY) : 1;

  typedef enum logic [2:0] {
    IDLE, DECODE, SELECTED, IGNORE, RD_SETTLE, RD_RPLY, WR_STROBE, WR_RPLY
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            sync_prev_reg;
  logic [12:0]     addr_reg;
  logic [15:0]     wdata_reg;
  logic [1:0]      bmask_reg;
  logic [1:0]      bmask_next;
  logic [15:0]     da_out_reg;
  logic            addr_load, wdata_load, capture;
  logic            unused_ad;

  assign unused_ad = ^bus_ad[21:16];

  // Byte lane gi is enabled for a word write, or for a byte write whose address LSB selects it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign bmask_next[gi] = !bus_wtbt || (addr_reg[0] == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_load  = 1'b0;
    wdata_load = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus_sync && !sync_prev_reg) begin
          addr_load  = bus_bs7;
          state_next = bus_bs7 ? DECODE : IGNORE;
        end
      end
      DECODE:   state_next = reg_addr_match ? SELECTED : IGNORE;
      IGNORE:   state_next = IGNORE;
      SELECTED: begin
        if (bus_din) begin
          cnt_next   = CW'(RPLY_DELAY - 1);
          state_next = RD_SETTLE;
        end else if (bus_dout) begin
          wdata_load = 1'b1;
          state_next = WR_STROBE;
        end
      end
      RD_SETTLE: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RD_RPLY;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RD_RPLY:   if (!bus_din) state_next = SELECTED;
      WR_STROBE: state_next = WR_RPLY;
      WR_RPLY:   if (!bus_dout) state_next = SELECTED;
      default:   state_next = IDLE;
    endcase
    // Losing SYNC aborts whatever is in flight, including a pending read capture.
    if (!bus_sync) begin
      state_next = IDLE;
      capture    = 1'b0;
      wdata_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      sync_prev_reg <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      bmask_reg     <= 2'b00;
      da_out_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      sync_prev_reg <= bus_sync;
      if (addr_load) addr_reg <= bus_ad[12:0];
      if (wdata_load) begin
        wdata_reg <= bus_ad[15:0];
        bmask_reg <= bmask_next;
      end
      if (capture) da_out_reg <= reg_rdata;
    end
  end

  // Handshake outputs drop in the same cycle SYNC is seen low.
  assign bus_rply   = bus_sync && ((state_reg == RD_RPLY) || (state_reg == WR_RPLY));
  assign bus_da_oe  = bus_sync && (state_reg == RD_RPLY);
  assign reg_rd     = capture;
  assign reg_wr     = bus_sync && (state_reg == WR_STROBE);
  assign bus_da_out = da_out_reg;
  assign reg_addr   = addr_reg;
  assign reg_wdata  = wdata_reg;
  assign reg_bmask  = bmask_reg;

endmodule

// File: tb/tb_qbus_reg_slave.sv
// Scoreboard bench for qbus_reg_slave: expected strobes and RPLY edges are queued
// with their cycle numbers when stimulus is driven and checked as the DUT emits them.
module tb_qbus_reg_slave;

  localparam int RD = 2;
  localparam int K_NONE = 0, K_RD = 1, K_WR = 2, K_RON_RD = 3, K_RON_WR = 4, K_ROFF = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_sync = 1'b0, bus_din = 1'b0, bus_dout = 1'b0, bus_wtbt = 1'b0, bus_bs7 = 1'b0;
  logic [21:0] bus_ad = '0;
  logic        bus_rply, bus_da_oe, reg_rd, reg_wr;
  logic [15:0] bus_da_out, reg_wdata;
  logic [12:0] reg_addr;
  logic [1:0]  reg_bmask;
  logic        reg_addr_match = 1'b0;
  logic [15:0] reg_rdata = '0;

  qbus_reg_slave #(.RPLY_DELAY(RD)) dut (
    .clk(clk), .reset_n(reset_n), .bus_sync(bus_sync), .bus_din(bus_din),
    .bus_dout(bus_dout), .bus_wtbt(bus_wtbt), .bus_bs7(bus_bs7), .bus_ad(bus_ad),
    .bus_rply(bus_rply), .bus_da_oe(bus_da_oe), .bus_da_out(bus_da_out),
    .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_bmask(reg_bmask), .reg_addr_match(reg_addr_match), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [17:0] val;
    logic [12:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   t0;
  logic [12:0] cur_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [17:0] v, input logic [12:0] a);
    exp_t e;
    e.kind = kind; e.cyc = c; e.val = v; e.addr = a;
    sb_q.push_back(e);
  endtask

  logic rd_prev = 1'b0, wr_prev = 1'b0, rply_prev = 1'b0;

  task automatic sb_event(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_event", kind, K_NONE);
      return;
    end
    e = sb_q.pop_front();
    $display("txn kind=%0d cycle=%0d addr=%o wdata=%h bmask=%b da_out=%o oe=%b",
             kind, cyc, reg_addr, reg_wdata, reg_bmask, bus_da_out, bus_da_oe);
    check("event_kind", kind, e.kind);
    check("event_cycle", cyc, e.cyc);
    case (kind)
      K_RD: begin
        check("rd_addr", reg_addr, e.addr);
        check("rd_wr_excl", reg_wr, 1'b0);
        check("rd_single", rd_prev, 1'b0);
      end
      K_WR: begin
        check("wr_data", reg_wdata, e.val[15:0]);
        check("wr_bmask", reg_bmask, e.val[17:16]);
        check("wr_addr", reg_addr, e.addr);
        check("wr_rd_excl", reg_rd, 1'b0);
        check("wr_single", wr_prev, 1'b0);
      end
      K_RON_RD: begin
        check("rply_rd_oe", bus_da_oe, 1'b1);
        check("rply_rd_data", bus_da_out, e.val[15:0]);
      end
      K_RON_WR: check("rply_wr_oe", bus_da_oe, 1'b0);
      K_ROFF:   check("rply_off_oe", bus_da_oe, 1'b0);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (reg_rd) sb_event(K_RD);
    if (reg_wr) sb_event(K_WR);
    if (bus_rply && !rply_prev) sb_event(bus_da_oe ? K_RON_RD : K_RON_WR);
    if (!bus_rply && rply_prev) sb_event(K_ROFF);
    rd_prev   = reg_rd;
    wr_prev   = reg_wr;
    rply_prev = bus_rply;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Address phase; returns in cycle 2 (SELECTED when decoded and matched).
  task automatic select(input logic bs7, input logic [21:0] ad, input logic match);
    bus_sync = 1'b1; bus_bs7 = bs7; bus_ad = ad; reg_addr_match = match;
    t0 = cyc;
    tick();
    if (bs7) begin
      cur_addr = ad[12:0];
      check("reg_addr_cycle1", reg_addr, cur_addr);
    end
    tick();
  endtask

  task automatic rd_phase(input logic [15:0] d);
    int n;
    n = cyc;
    bus_din = 1'b1; reg_rdata = d;
    push(K_RD, n + RD, 18'(d), cur_addr);
    push(K_RON_RD, n + RD + 1, 18'(d), cur_addr);
    tick(RD + 3);
    bus_din = 1'b0;
    push(K_ROFF, cyc + 1, '0, cur_addr);
    tick(2);
  endtask

  task automatic wr_phase(input logic wtbt, input logic [15:0] d, input logic [1:0] bm);
    int n;
    n = cyc;
    bus_dout = 1'b1; bus_wtbt = wtbt; bus_ad = {6'b0, d};
    push(K_WR, n + 1, {bm, d}, cur_addr);
    push(K_RON_WR, n + 2, '0, cur_addr);
    tick(4);
    bus_dout = 1'b0;
    push(K_ROFF, cyc + 1, '0, cur_addr);
    tick(2);
  endtask

  task automatic end_sync();
    bus_sync = 1'b0; bus_bs7 = 1'b0; bus_wtbt = 1'b0;
    tick(2);
  endtask

  initial begin
    #3;
    check("rst_rply", bus_rply, 1'b0);
    check("rst_oe", bus_da_oe, 1'b0);
    check("rst_rd_wr", {reg_rd, reg_wr}, 2'b00);
    check("rst_da_out", bus_da_out, 16'h0);
    check("rst_addr", reg_addr, 13'h0);
    check("rst_wdata", reg_wdata, 16'h0);
    check("rst_bmask", reg_bmask, 2'b00);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // DATI: DIN in cycle 3
    select(1'b1, 22'o17776, 1'b1);
    tick();
    rd_phase(16'o123456);
    end_sync();

    // DATOB to an odd address: high byte lane
    select(1'b1, 22'o0001, 1'b1);
    tick();
    wr_phase(1'b1, 16'hA55A, 2'b10);
    end_sync();

    // DATOB to an even address: low byte lane
    select(1'b1, 22'o0100, 1'b1);
    wr_phase(1'b1, 16'h3C3C, 2'b01);
    end_sync();

    // No match: nothing may respond
    select(1'b1, 22'o17000, 1'b0);
    bus_din = 1'b1; tick(6); bus_din = 1'b0;
    bus_dout = 1'b1; tick(4); bus_dout = 1'b0;
    end_sync();

    // bs7 = 0: ignored, reg_addr keeps the previous latch
    select(1'b0, 22'o17776, 1'b1);
    check("addr_hold_bs7_0", reg_addr, 13'o17000);
    bus_din = 1'b1; tick(6); bus_din = 1'b0;
    end_sync();

    // DATIO: read then word write under one SYNC
    select(1'b1, 22'o17700, 1'b1);
    tick();
    rd_phase(16'o070707);
    wr_phase(1'b0, 16'h1234, 2'b11);
    check("datio_addr", reg_addr, 13'o17700);
    end_sync();

    // Abort: SYNC drops in the cycle the read would have been captured
    select(1'b1, 22'o17720, 1'b1);
    tick();
    bus_din = 1'b1; reg_rdata = 16'hDEAD;
    tick(RD);
    bus_sync = 1'b0; bus_din = 1'b0;
    tick();
    // New SYNC right away must decode normally
    select(1'b1, 22'o17740, 1'b1);
    rd_phase(16'o007070);
    end_sync();

    // Reset asserted during WR_RPLY
    select(1'b1, 22'o17702, 1'b1);
    wr_phase(1'b0, 16'h5555, 2'b11);
    bus_dout = 1'b1; bus_wtbt = 1'b0; bus_ad = 22'h00BEEF;
    push(K_WR, cyc + 1, {2'b11, 16'hBEEF}, cur_addr);
    push(K_RON_WR, cyc + 2, '0, cur_addr);
    tick(3);
    check("pre_reset_rply", bus_rply, 1'b1);
    reset_n = 1'b0;
    push(K_ROFF, cyc, '0, cur_addr);
    #1;
    check("async_rst_rply", bus_rply, 1'b0);
    check("async_rst_outs", {bus_da_oe, reg_rd, reg_wr}, 3'b000);
    check("async_rst_da_out", bus_da_out, 16'h0);
    check("async_rst_addr", reg_addr, 13'h0);
    check("async_rst_wdata", reg_wdata, 16'h0);
    check("async_rst_bmask", reg_bmask, 2'b00);
    bus_dout = 1'b0; bus_sync = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    select(1'b1, 22'o17776, 1'b1);
    rd_phase(16'o111111);
    end_sync();

    tick(3);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
